// File: rtl/mulbus_pkg.sv
// Shared constants and state types for the multiplier-peripheral bus initiator.
package mulbus_pkg;

  localparam logic [15:0] ADDR_A1   = 16'h0380;
  localparam logic [15:0] ADDR_A2   = 16'h0388;
  localparam logic [15:0] ADDR_W    = 16'h0390;
  localparam logic [15:0] ADDR_L    = 16'h0398;
  localparam logic [15:0] ADDR_CTRL = 16'h03A0;

  localparam logic [1:0] STATUS_DONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A1,
    ST_WR_A2,
    ST_WR_GO,
    ST_POLL,
    ST_RD_W,
    ST_RD_L,
    ST_RESP
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_t;

endpackage

// File: rtl/mulbus_access.sv
// Single strobe-bus access engine: setup, strobe and hold phases, all bus
// outputs driven straight from flops.
module mulbus_access
  import mulbus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        rnw,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] m_saddress,
  output logic        m_srd,
  output logic        m_swr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  phase_t          phase;
  logic [CW-1:0]   cnt;
  logic            rnw_q;

  // A new access may start in the hold cycle of the previous one, so
  // consecutive accesses have no idle gap.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      phase      <= PH_IDLE;
      cnt        <= '0;
      rnw_q      <= 1'b0;
      m_saddress <= '0;
      m_wdata    <= '0;
      m_srd      <= 1'b0;
      m_swr      <= 1'b0;
    end else begin
      case (phase)
        PH_IDLE, PH_HOLD: begin
          if (start) begin
            phase      <= PH_SETUP;
            cnt        <= '0;
            rnw_q      <= rnw;
            m_saddress <= addr;
            m_wdata    <= wdata;
          end else begin
            phase <= PH_IDLE;
          end
        end
        PH_SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            phase <= PH_STROBE;
            cnt   <= '0;
            m_srd <= rnw_q;
            m_swr <= !rnw_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PH_STROBE: begin
          if (cnt == CW'(STROBE_CYCLES - 1)) begin
            phase <= PH_HOLD;
            cnt   <= '0;
            m_srd <= 1'b0;
            m_swr <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

  // Read data is taken by the sequencer at the end of the hold cycle.
  assign done  = (phase == PH_HOLD);
  assign rdata = m_rdata;

endmodule

// File: rtl/mulbus_initiator.sv
// Runs the complete multiply register sequence on the peripheral strobe bus
// for one command at a time and returns product low word and popcount.
module mulbus_initiator
  import mulbus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int POLL_LIMIT    = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_w,
  output logic [23:0] rsp_l,
  output logic        rsp_timeout,
  output logic [15:0] m_saddress,
  output logic        m_srd,
  output logic        m_swr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  seq_state_t      state;
  logic [23:0]     a2_reg;
  logic [PW-1:0]   poll_cnt;

  logic            acc_start;
  logic            acc_rnw;
  logic [15:0]     acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_done;
  logic [31:0]     acc_rdata;
  logic            status_done;
  logic            poll_last;

  assign status_done = (acc_rdata[1:0] == STATUS_DONE);
  assign poll_last   = (poll_cnt == PW'(POLL_LIMIT - 1));

  // Next access is requested in the same cycle the current one completes.
  // A1 goes straight from the command port into the engine's data flop.
  always_comb begin
    acc_start = 1'b0;
    acc_rnw   = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (state)
      ST_IDLE: if (cmd_valid && cmd_ready) begin
        acc_start = 1'b1;
        acc_addr  = ADDR_A1;
        acc_wdata = {8'h0, cmd_a1};
      end
      ST_WR_A1: if (acc_done) begin
        acc_start = 1'b1;
        acc_addr  = ADDR_A2;
        acc_wdata = {8'h0, a2_reg};
      end
      ST_WR_A2: if (acc_done) begin
        acc_start = 1'b1;
        acc_addr  = ADDR_CTRL;
      end
      ST_WR_GO: if (acc_done) begin
        acc_start = 1'b1;
        acc_rnw   = 1'b1;
        acc_addr  = ADDR_CTRL;
      end
      ST_POLL: if (acc_done && (status_done || !poll_last)) begin
        acc_start = 1'b1;
        acc_rnw   = 1'b1;
        acc_addr  = status_done ? ADDR_W : ADDR_CTRL;
      end
      ST_RD_W: if (acc_done) begin
        acc_start = 1'b1;
        acc_rnw   = 1'b1;
        acc_addr  = ADDR_L;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      a2_reg      <= '0;
      poll_cnt    <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_w       <= '0;
      rsp_l       <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (cmd_valid && cmd_ready) begin
          a2_reg      <= cmd_a2;
          poll_cnt    <= '0;
          cmd_ready   <= 1'b0;
          rsp_w       <= '0;
          rsp_l       <= '0;
          rsp_timeout <= 1'b0;
          state       <= ST_WR_A1;
        end
        ST_WR_A1: if (acc_done) state <= ST_WR_A2;
        ST_WR_A2: if (acc_done) state <= ST_WR_GO;
        ST_WR_GO: if (acc_done) state <= ST_POLL;
        ST_POLL: if (acc_done) begin
          if (status_done) begin
            state <= ST_RD_W;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            if (poll_last) begin
              rsp_timeout <= 1'b1;
              rsp_w       <= '0;
              rsp_l       <= '0;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end
          end
        end
        ST_RD_W: if (acc_done) begin
          rsp_w <= acc_rdata;
          state <= ST_RD_L;
        end
        ST_RD_L: if (acc_done) begin
          rsp_l     <= acc_rdata[23:0];
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mulbus_access #(
    .SETUP_CYCLES  (SETUP_CYCLES),
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_access (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (acc_start),
    .rnw        (acc_rnw),
    .addr       (acc_addr),
    .wdata      (acc_wdata),
    .done       (acc_done),
    .rdata      (acc_rdata),
    .m_saddress (m_saddress),
    .m_srd      (m_srd),
    .m_swr      (m_swr),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata)
  );

endmodule

// File: tb/tb_mulbus_initiator.sv
// Directed bench: two initiators (default timing, and 3/1 timing with a
// 4-poll limit) each driving a behavioural multiplier peripheral.
module tb_mulbus_initiator;
  import mulbus_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [23:0] cmd_a1 [2];
  logic [23:0] cmd_a2 [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_w [2];
  logic [23:0] rsp_l [2];
  logic        rsp_timeout [2];
  logic [15:0] m_saddress [2];
  logic        m_srd [2];
  logic        m_swr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy [2];
  logic [48:0] log_e [2][128];
  int log_n [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mulbus_initiator u_dut0 (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_a1(cmd_a1[0]), .cmd_a2(cmd_a2[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_w(rsp_w[0]), .rsp_l(rsp_l[0]), .rsp_timeout(rsp_timeout[0]),
    .m_saddress(m_saddress[0]), .m_srd(m_srd[0]), .m_swr(m_swr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(m_rdata[0])
  );

  mulbus_initiator #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .POLL_LIMIT(4)) u_dut1 (
    .clk(clk), .n_reset(n_reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_a1(cmd_a1[1]), .cmd_a2(cmd_a2[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_w(rsp_w[1]), .rsp_l(rsp_l[1]), .rsp_timeout(rsp_timeout[1]),
    .m_saddress(m_saddress[1]), .m_srd(m_srd[1]), .m_swr(m_swr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(m_rdata[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] ent(input logic rnw, input logic [15:0] a, input logic [31:0] d);
    return {rnw, a, d};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_bus
    localparam int STRB = (gi == 0) ? 2 : 1;
    logic [23:0] a1_m = '0;
    logic [23:0] a2_m = '0;
    logic [31:0] w_m = '0;
    int          busy_left = 0;
    logic        srd_q = 1'b0;
    logic        swr_q = 1'b0;
    logic        prev_act = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_wd = '0;
    int          wid = 0;
    logic        act;

    // Peripheral model: registers take effect on the strobe's rising edge.
    always @(posedge clk) begin
      if (m_swr[gi] && !swr_q) begin
        case (m_saddress[gi])
          ADDR_A1:   a1_m <= m_wdata[gi][23:0];
          ADDR_A2:   a2_m <= m_wdata[gi][23:0];
          ADDR_CTRL: begin
            w_m       <= {8'h0, a1_m} * {8'h0, a2_m};
            busy_left <= busy[gi];
          end
          default: ;
        endcase
      end
      if (m_srd[gi] && !srd_q) begin
        case (m_saddress[gi])
          ADDR_CTRL: begin
            m_rdata[gi] <= (busy_left > 0) ? 32'h1 : 32'h3;
            if (busy_left > 0) busy_left <= busy_left - 1;
          end
          ADDR_W:  m_rdata[gi] <= w_m;
          ADDR_L:  m_rdata[gi] <= 32'($countones(w_m));
          default: m_rdata[gi] <= 32'h0;
        endcase
      end
      srd_q <= m_srd[gi];
      swr_q <= m_swr[gi];
    end

    // Protocol checker and bus trace logger.
    always @(negedge clk) begin
      act = m_srd[gi] | m_swr[gi];
      if (!n_reset) begin
        prev_act <= 1'b0;
        wid      <= 0;
      end else begin
        chk($sformatf("bus%0d_srd_swr_exclusive", gi), 64'(m_srd[gi] & m_swr[gi]), 64'd0);
        if (act || prev_act) begin
          chk($sformatf("bus%0d_addr_stable", gi), 64'(m_saddress[gi]), 64'(prev_addr));
          chk($sformatf("bus%0d_wdata_stable", gi), 64'(m_wdata[gi]), 64'(prev_wd));
        end
        if (act) begin
          wid <= wid + 1;
        end else if (prev_act) begin
          chk($sformatf("bus%0d_strobe_width", gi), 64'(wid), 64'(STRB));
          wid <= 0;
        end
        if (act && !prev_act && log_n[gi] < 128) begin
          log_e[gi][log_n[gi]] <= {m_srd[gi], m_saddress[gi], m_wdata[gi]};
          log_n[gi] <= log_n[gi] + 1;
        end
        prev_act <= act;
      end
      prev_addr <= m_saddress[gi];
      prev_wd   <= m_wdata[gi];
    end
  end

  task automatic send(input int i, input logic [23:0] a1, input logic [23:0] a2, output int hs);
    int n;
    @(negedge clk);
    cmd_a1[i] = a1;
    cmd_a2[i] = a2;
    cmd_valid[i] = 1'b1;
    n = 0;
    while (!cmd_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", 64'(cmd_ready[i]), 64'd1);
    @(posedge clk);
    #1 cmd_valid[i] = 1'b0;
    @(negedge clk);
    hs = cyc;
  endtask

  task automatic wait_rsp(input int i, output int t);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_seen", 64'(rsp_valid[i]), 64'd1);
    t = cyc;
  endtask

  task automatic rsp_hs(input int i);
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[i] = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rsp", 64'(cmd_ready[i]), 64'd1);
    chk("rsp_valid_dropped", 64'(rsp_valid[i]), 64'd0);
  endtask

  initial begin
    int hs;
    int t;
    int base;
    int n;
    logic [48:0] exp_e [8];

    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
      cmd_a1[i] = '0;
      cmd_a2[i] = '0;
      busy[i] = 0;
    end
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready[0]), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("rst_rsp_w", 64'(rsp_w[0]), 64'd0);
    chk("rst_rsp_l", 64'(rsp_l[0]), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout[0]), 64'd0);
    chk("rst_saddress", 64'(m_saddress[0]), 64'd0);
    chk("rst_srd", 64'(m_srd[0]), 64'd0);
    chk("rst_swr", 64'(m_swr[0]), 64'd0);
    chk("rst_wdata", 64'(m_wdata[0]), 64'd0);
    chk("rst_cmd_ready_1", 64'(cmd_ready[1]), 64'd1);
    n_reset = 1'b1;

    // Basic multiply, two busy polls then done.
    busy[0] = 2;
    base = log_n[0];
    send(0, 24'd3, 24'd5, hs);
    wait_rsp(0, t);
    $display("basic: a1=3 a2=5 w=0x%08h l=%0d to=%0d lat=%0d", rsp_w[0], rsp_l[0], rsp_timeout[0], t - hs);
    chk("basic_latency", 64'(t - hs), 64'd32);
    chk("basic_w", 64'(rsp_w[0]), 64'h0000000F);
    chk("basic_l", 64'(rsp_l[0]), 64'd4);
    chk("basic_timeout", 64'(rsp_timeout[0]), 64'd0);
    chk("basic_bus_count", 64'(log_n[0] - base), 64'd8);
    exp_e[0] = ent(1'b0, 16'h0380, 32'd3);
    exp_e[1] = ent(1'b0, 16'h0388, 32'd5);
    exp_e[2] = ent(1'b0, 16'h03A0, 32'd0);
    exp_e[3] = ent(1'b1, 16'h03A0, 32'd0);
    exp_e[4] = ent(1'b1, 16'h03A0, 32'd0);
    exp_e[5] = ent(1'b1, 16'h03A0, 32'd0);
    exp_e[6] = ent(1'b1, 16'h0390, 32'd0);
    exp_e[7] = ent(1'b1, 16'h0398, 32'd0);
    for (int j = 0; j < 8; j++)
      chk($sformatf("basic_bus%0d", j), 64'(log_e[0][base + j]), 64'(exp_e[j]));

    // Backpressure with a second command waiting.
    busy[0] = 0;
    cmd_a1[0] = 24'hFFFFFF;
    cmd_a2[0] = 24'hFFFFFF;
    cmd_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      chk("bp_rsp_w", 64'(rsp_w[0]), 64'h0000000F);
      chk("bp_cmd_ready", 64'(cmd_ready[0]), 64'd0);
      chk("bp_bus_idle", 64'(m_srd[0] | m_swr[0]), 64'd0);
      @(negedge clk);
    end
    base = log_n[0];
    rsp_hs(0);
    @(posedge clk);
    #1 cmd_valid[0] = 1'b0;
    @(negedge clk);
    hs = cyc;
    chk("max_accepted", 64'(cmd_ready[0]), 64'd0);
    wait_rsp(0, t);
    $display("max: a1=ffffff a2=ffffff w=0x%08h l=%0d to=%0d lat=%0d", rsp_w[0], rsp_l[0], rsp_timeout[0], t - hs);
    chk("max_latency", 64'(t - hs), 64'd24);
    chk("max_w", 64'(rsp_w[0]), 64'hFE000001);
    chk("max_l", 64'(rsp_l[0]), 64'd8);
    chk("max_timeout", 64'(rsp_timeout[0]), 64'd0);
    chk("max_bus_count", 64'(log_n[0] - base), 64'd6);
    chk("max_wr_a1", 64'(log_e[0][base]), 64'(ent(1'b0, 16'h0380, 32'h00FFFFFF)));
    chk("max_wr_a2", 64'(log_e[0][base + 1]), 64'(ent(1'b0, 16'h0388, 32'h00FFFFFF)));
    rsp_hs(0);

    // Timeout on the 3/1-timing instance, status stuck busy.
    busy[1] = 1000;
    base = log_n[1];
    send(1, 24'd1, 24'd2, hs);
    wait_rsp(1, t);
    $display("timeout: w=0x%08h l=%0d to=%0d lat=%0d", rsp_w[1], rsp_l[1], rsp_timeout[1], t - hs);
    chk("to_latency", 64'(t - hs), 64'd35);
    chk("to_timeout", 64'(rsp_timeout[1]), 64'd1);
    chk("to_w", 64'(rsp_w[1]), 64'd0);
    chk("to_l", 64'(rsp_l[1]), 64'd0);
    chk("to_bus_count", 64'(log_n[1] - base), 64'd7);
    for (int j = 3; j < 7; j++)
      chk($sformatf("to_poll%0d", j), 64'(log_e[1][base + j]), 64'(ent(1'b1, 16'h03A0, 32'd0)));
    rsp_hs(1);

    // Normal command on the 3/1-timing instance.
    busy[1] = 2;
    send(1, 24'h000123, 24'h000010, hs);
    wait_rsp(1, t);
    $display("alt: a1=123 a2=10 w=0x%08h l=%0d to=%0d lat=%0d", rsp_w[1], rsp_l[1], rsp_timeout[1], t - hs);
    chk("alt_latency", 64'(t - hs), 64'd40);
    chk("alt_w", 64'(rsp_w[1]), 64'h00001230);
    chk("alt_l", 64'(rsp_l[1]), 64'd4);
    chk("alt_timeout", 64'(rsp_timeout[1]), 64'd0);
    rsp_hs(1);

    // Reset asserted while the status read strobe is high.
    busy[0] = 1000;
    send(0, 24'd7, 24'd7, hs);
    n = 0;
    while (!m_srd[0] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("poll_strobe_seen", 64'(m_srd[0]), 64'd1);
    chk("poll_addr", 64'(m_saddress[0]), 64'(ADDR_CTRL));
    #2 n_reset = 1'b0;
    #1;
    $display("reset mid-poll: srd=%0d addr=0x%04h cmd_ready=%0d", m_srd[0], m_saddress[0], cmd_ready[0]);
    chk("arst_srd", 64'(m_srd[0]), 64'd0);
    chk("arst_swr", 64'(m_swr[0]), 64'd0);
    chk("arst_saddress", 64'(m_saddress[0]), 64'd0);
    chk("arst_wdata", 64'(m_wdata[0]), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready[0]), 64'd1);
    chk("arst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    chk("arst_rsp_timeout", 64'(rsp_timeout[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b1;

    busy[0] = 1;
    send(0, 24'h000100, 24'h000100, hs);
    wait_rsp(0, t);
    $display("after reset: a1=100 a2=100 w=0x%08h l=%0d to=%0d lat=%0d", rsp_w[0], rsp_l[0], rsp_timeout[0], t - hs);
    chk("post_latency", 64'(t - hs), 64'd28);
    chk("post_w", 64'(rsp_w[0]), 64'h00010000);
    chk("post_l", 64'(rsp_l[0]), 64'd1);
    chk("post_timeout", 64'(rsp_timeout[0]), 64'd0);
    rsp_hs(0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
